// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM state encoding,
// rstatus codes and the default timeout limit.
package md_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } md_state_e;

    localparam logic [4:0]  RSTATUS_REG        = 5'd30;
    localparam logic [31:0] MULT_EXC_CODE      = 32'd4;
    localparam logic [31:0] DIV_EXC_CODE       = 32'd5;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 40;

    // rstatus code reported for a failed op of the given type
    function automatic logic [31:0] exc_code(input logic is_div);
        return is_div ? DIV_EXC_CODE : MULT_EXC_CODE;
    endfunction

endpackage

// File: rtl/md_watchdog.sv
// Clearable saturating cycle counter with a terminal flag, used to abort a
// multdiv operation that never reports ready. Only built when MD_TIMEOUT_EN
// is defined; the default build has no counter at all.
`ifdef MD_TIMEOUT_EN
module md_watchdog #(
    parameter int unsigned LIMIT = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic inc_i,
    output logic terminal_o
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // next count: clear wins, otherwise count up and stick at LIMIT
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {CW{1'b0}};
        end else if (inc_i && (count_q != CW'(LIMIT))) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // counter register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    // flag the cycle whose increment makes the count reach LIMIT
    assign terminal_o = inc_i && (count_q == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/md_scheduler.sv
// Sequencer for the shared multi-cycle multiply/divide unit. Captures an op
// from DX, pulses the unit start for one cycle, stalls the front end while
// the unit works, then emits a one-cycle writeback record.
// Optional feature: define MD_TIMEOUT_EN to abort a BUSY op after
// TIMEOUT_CYCLES cycles without md_ready (reported as an exception).
module md_scheduler
    import md_pkg::*;
`ifdef MD_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)
`endif
(
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_is_div,
    input  logic [31:0] issue_opA,
    input  logic [31:0] issue_opB,
    input  logic [4:0]  issue_rd,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic [31:0] md_opA,
    output logic [31:0] md_opB,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        wb_exception
);

    md_state_e   state_q, state_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [4:0]  rd_q, rd_d;
    logic        is_div_q, is_div_d;
    logic        ctrl_mult_q, ctrl_mult_d;
    logic        ctrl_div_q, ctrl_div_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_reg_q, wb_reg_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_exc_q, wb_exc_d;

    logic        timeout_s;
    logic        capture_s;
    logic        finish_s;
    logic        exc_s;
    logic        stall_s;

`ifdef MD_TIMEOUT_EN
    md_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (state_q == ST_START),
        .inc_i      ((state_q == ST_BUSY) && !md_ready),
        .terminal_o (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // an op is accepted whenever the sequencer is free (idle, or finishing)
    assign capture_s = issue_valid && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    // md_ready has priority over the timeout; it is only honoured in BUSY
    assign finish_s  = (state_q == ST_BUSY) && (md_ready || timeout_s);

    // state register, synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (issue_valid) state_d = ST_START;
                else             state_d = ST_IDLE;
            end
            ST_START: state_d = ST_BUSY;
            ST_BUSY: begin
                if (md_ready || timeout_s) state_d = ST_DONE;
                else                       state_d = ST_BUSY;
            end
            ST_DONE: begin
                if (issue_valid) state_d = ST_START;
                else             state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // output/datapath next values: capture, start pulses, writeback record
    always_comb begin
        opa_d       = opa_q;
        opb_d       = opb_q;
        rd_d        = rd_q;
        is_div_d    = is_div_q;
        ctrl_mult_d = 1'b0;
        ctrl_div_d  = 1'b0;
        wb_valid_d  = 1'b0;
        wb_reg_d    = 5'd0;
        wb_data_d   = 32'd0;
        wb_exc_d    = 1'b0;
        exc_s       = 1'b0;

        if (capture_s) begin
            opa_d       = issue_opA;
            opb_d       = issue_opB;
            rd_d        = issue_rd;
            is_div_d    = issue_is_div;
            ctrl_mult_d = !issue_is_div;
            ctrl_div_d  = issue_is_div;
        end else begin
            ctrl_mult_d = 1'b0;
            ctrl_div_d  = 1'b0;
        end

        if (finish_s) begin
            exc_s      = md_ready ? md_exception : 1'b1;
            wb_valid_d = 1'b1;
            wb_exc_d   = exc_s;
            if (exc_s) begin
                wb_reg_d  = RSTATUS_REG;
                wb_data_d = exc_code(is_div_q);
            end else begin
                wb_reg_d  = rd_q;
                wb_data_d = md_result;
            end
        end else begin
            wb_valid_d = 1'b0;
        end

        stall_s = capture_s || (state_q == ST_START) || (state_q == ST_BUSY);
    end

    // datapath and output registers, synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            opa_q       <= 32'd0;
            opb_q       <= 32'd0;
            rd_q        <= 5'd0;
            is_div_q    <= 1'b0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_reg_q    <= 5'd0;
            wb_data_q   <= 32'd0;
            wb_exc_q    <= 1'b0;
        end else begin
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            rd_q        <= rd_d;
            is_div_q    <= is_div_d;
            ctrl_mult_q <= ctrl_mult_d;
            ctrl_div_q  <= ctrl_div_d;
            wb_valid_q  <= wb_valid_d;
            wb_reg_q    <= wb_reg_d;
            wb_data_q   <= wb_data_d;
            wb_exc_q    <= wb_exc_d;
        end
    end

    assign md_ctrl_mult = ctrl_mult_q;
    assign md_ctrl_div  = ctrl_div_q;
    assign md_opA       = opa_q;
    assign md_opB       = opb_q;
    assign wb_valid     = wb_valid_q;
    assign wb_reg       = wb_reg_q;
    assign wb_data      = wb_data_q;
    assign wb_exception = wb_exc_q;
    // combinational from issue_valid so DX sees the stall in the issue cycle
    assign stall        = stall_s;

endmodule
